// File: rtl/lsu_dmem_slave_if.sv
// lsu_dmem_slave_if: LSU-to-data-memory bus, requester drives the _i side, responder drives the _o side
interface lsu_dmem_slave_if;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_dat_i;
    logic [3:0]  lsu_sel_i;
    logic        lsu_we_i;
    logic        lsu_re_i;
    logic [31:0] lsu_dat_o;
    logic        lsu_ack_o;
    logic        lsu_err_o;
    logic        lsu_busy_o;
    modport slave (
        input  lsu_addr_i, lsu_dat_i, lsu_sel_i, lsu_we_i, lsu_re_i,
        output lsu_dat_o, lsu_ack_o, lsu_err_o, lsu_busy_o
    );
    modport master (
        output lsu_addr_i, lsu_dat_i, lsu_sel_i, lsu_we_i, lsu_re_i,
        input  lsu_dat_o, lsu_ack_o, lsu_err_o, lsu_busy_o
    );
endinterface

// File: rtl/lsu_dmem_slave.sv
// lsu_dmem_slave: wait-stated word RAM responder for the LSU bus
module lsu_dmem_slave #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    lsu_dmem_slave_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
    localparam int CW = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    logic [31:0]           r_mem [2**ADDR_WIDTH];
    logic [1:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           r_dat;
    logic [31:0]           r_rdat;
    logic [3:0]            r_sel;
    logic                  r_we;
    logic                  r_err;
    logic                  r_ack;
    logic                  r_nak;
    logic [31:0]           w_off;
    logic                  w_req;
    logic                  w_err;
    logic                  w_go;
    assign w_off = bus.lsu_addr_i - BASE_ADDR;
    assign w_req = bus.lsu_we_i | bus.lsu_re_i;
    // unsigned offset: addresses below BASE_ADDR wrap high and land out of range
    assign w_err = (bus.lsu_addr_i[1:0] != 2'b00) | ((w_off >> (ADDR_WIDTH + 2)) != 32'd0)
                 | (bus.lsu_we_i & bus.lsu_re_i);
    assign w_go  = (r_state == RESP) && !r_err;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_nak   <= 1'b0;
            r_rdat  <= '0;
        end else begin
            r_ack <= w_go;
            r_nak <= (r_state == RESP) && r_err;
            case (r_state)
                IDLE: if (w_req) begin
                    r_state <= WAIT_STATES > 0 ? WAIT : RESP;
                    r_cnt   <= LOAD;
                end
                WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) r_state <= RESP;
                end
                default: begin
                    if (w_go && !r_we) r_rdat <= r_mem[r_idx];
                    r_state <= IDLE;
                end
            endcase
        end
    end
    // holding registers and RAM; a reset landing on RESP suppresses the write
    always_ff @(posedge clk_i) begin
        if (r_state == IDLE && w_req) begin
            r_idx <= w_off[ADDR_WIDTH+1:2];
            r_dat <= bus.lsu_dat_i;
            r_sel <= bus.lsu_sel_i;
            r_we  <= bus.lsu_we_i;
            r_err <= w_err;
        end
        if (!rst_i && w_go && r_we)
            for (int b = 0; b < 4; b++)
                if (r_sel[b]) r_mem[r_idx][8*b +: 8] <= r_dat[8*b +: 8];
    end
    assign bus.lsu_dat_o  = r_rdat;
    assign bus.lsu_ack_o  = r_ack;
    assign bus.lsu_err_o  = r_nak;
    assign bus.lsu_busy_o = r_state != IDLE;
endmodule

// File: doc/lsu_dmem_slave.md
Name: lsu_dmem_slave

Overview:
- Data-memory responder at the far end of the LSU bus.
- Accepts word-aligned requests from the load/store unit: write with byte-lane select, or read of a full word.
- Services each request after a programmable number of wait states, then returns a one-cycle ack or err.
- Backed by an internal word-addressed RAM. Lane extraction and sign extension stay in the LSU.

Parameters:
- ADDR_WIDTH, 10: word-address bits; RAM depth is 2**ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to 4*2**ADDR_WIDTH.
- WAIT_STATES, 1: cycles spent in WAIT before the response; 0 allowed.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- lsu_addr_i  in  32  byte address of the request; expected word-aligned.
- lsu_dat_i  in  32  write data; lanes already replicated by the LSU.
- lsu_sel_i  in  4  byte-lane enables; bit n selects bits 8n+7:8n.
- lsu_we_i  in  1  write request, level.
- lsu_re_i  in  1  read request, level.
- lsu_dat_o  out  32  read data.
- lsu_ack_o  out  1  one-cycle successful completion.
- lsu_err_o  out  1  one-cycle failed completion.
- lsu_busy_o  out  1  high while a request is in flight.

Behaviour:
- Clock and reset: single clock clk_i; synchronous active-high reset rst_i.
- Reset values: state=IDLE, lsu_ack_o=0, lsu_err_o=0, lsu_dat_o=0, wait counter=0. RAM contents are not reset.
- States: IDLE, WAIT, RESP. lsu_busy_o = (state != IDLE), decoded combinationally from state.
- IDLE:
  - If lsu_we_i or lsu_re_i is high, capture addr, data, sel, we, and the error flag into holding registers.
  - Go to WAIT when WAIT_STATES>0, otherwise go to RESP. Load counter with WAIT_STATES-1.
- WAIT: decrement counter; go to RESP when counter==0. Inputs are ignored; only the captured copy is used.
- RESP (one cycle), on the edge leaving RESP:
  - Perform the access and pulse ack or err for exactly one cycle.
  - Return to IDLE.
- Latency: a request sampled in IDLE at edge N is completed at edge N+WAIT_STATES+1 (ack/err high in the following cycle).
  - WAIT_STATES=0 gives ack one cycle after capture.
  - Minimum spacing between accepted requests is WAIT_STATES+2 cycles.
- Error conditions, evaluated at capture:
  - Address misaligned (addr[1:0]!=0).
  - Address out of range: (addr-BASE_ADDR)>>2 >= 2**ADDR_WIDTH, unsigned, wrap-around counts as out of range.
  - lsu_we_i and lsu_re_i both high.
- On error: lsu_err_o pulses instead of ack, no RAM write occurs, and lsu_dat_o is unchanged.
- Write: for each sel bit set, update that byte of RAM[(addr-BASE_ADDR)>>2]; other bytes keep their value. sel=0000 still acks and changes nothing.
- Read: lsu_dat_o is loaded with the full word on the edge that raises ack and holds until the next successful read. sel is ignored.
- Handshake:
  - The requester holds its request until ack or err, and drops it in the ack/err cycle.
  - A request level seen in IDLE after the response is a new request; if still high, it is re-executed.
- Reset mid-operation: abort to IDLE and discard the pending write (RAM unchanged). No ack or err is issued for the aborted request.
- ack and err are never high together and never high outside the cycle after RESP.

Test Plan:
- Reset, WAIT_STATES=1: rst_i high for 2 cycles. Required: ack=0, err=0, busy=0, dat_o=0.
- Word write then read: write addr 0x10, data 0xDEADBEEF, sel 1111; ack 2 cycles after capture. Read 0x10 -> dat_o=0xDEADBEEF with ack.
- Byte-lane merge: after the 0xDEADBEEF write, write addr 0x10, data 0x55555555, sel 0100. Read 0x10 -> 0xDE55BEEF.
- Errors:
  - Read 0x12 -> err pulse, dat_o keeps its previous value.
  - With ADDR_WIDTH=10, read 0x1000 -> err.
  - we and re both high -> err, no RAM change.
- Latency sweep: WAIT_STATES=0 and 3 -> ack at exactly capture+1 and capture+4. busy is high from capture until ack, and the ack pulse is one cycle wide.
- Reset mid-write: write 0x20, data 0x12345678; assert rst_i during WAIT. Required: no ack. A later read of 0x20 returns the prior contents (0x0 after a preload of zero).
